// File: rtl/vlane_ret_pkg.sv
// vlane_ret_pkg: shared types, lane count and beat-counter width helper for the lane return path
package vlane_ret_pkg;
    localparam int VLANE_NUM = 4;
    typedef enum logic [1:0] {RET_IDLE, RET_COLLECT, RET_DRAIN} ret_state_e;
    typedef struct packed {
        logic [VLANE_NUM-1:0]       mask;
        logic [VLANE_NUM-1:0][31:0] data;
    } ret_beat_t;
    function automatic int ret_bw(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction
endpackage

// File: rtl/vlane_ret_fifo.sv
// vlane_ret_fifo: synchronous beat FIFO; DEPTH must be a power of 2
module vlane_ret_fifo
    import vlane_ret_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push,
    input  logic      pop,
    input  ret_beat_t din,
    output ret_beat_t dout,
    output logic      full,
    output logic      empty
);
    localparam int AW = $clog2(DEPTH);
    ret_beat_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign dout  = mem[rd_ptr];
    // pointers wrap naturally; occupancy tracks push/pop, unchanged when both fire
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/vlane_driver_return_path.sv
// vlane_driver_return_path: gathers lane elements into beats per write port; VLANE_RET_PROTO_CHECK_EN enables sticky protocol_err_o
module vlane_driver_return_path
    import vlane_ret_pkg::*;
#(
    parameter  int W_PORTS_NUM = 4,
    parameter  int FIFO_DEPTH  = 4,
    parameter  int MAX_BEATS   = 256,
    localparam int BW          = ret_bw(MAX_BEATS)
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic [W_PORTS_NUM-1:0]                       start_i,
    input  logic [W_PORTS_NUM-1:0][BW-1:0]               beats_i,
    input  logic [W_PORTS_NUM-1:0][VLANE_NUM-1:0]        lane_mask_i,
    input  logic [VLANE_NUM-1:0][W_PORTS_NUM-1:0]        lane_valid_i,
    input  logic [VLANE_NUM-1:0][W_PORTS_NUM-1:0][31:0]  lane_data_i,
    output logic [VLANE_NUM-1:0][W_PORTS_NUM-1:0]        lane_ready_o,
    output logic [W_PORTS_NUM-1:0]                       store_valid_o,
    input  logic [W_PORTS_NUM-1:0]                       store_ready_i,
    output logic [W_PORTS_NUM-1:0][VLANE_NUM-1:0][31:0]  store_data_o,
    output logic [W_PORTS_NUM-1:0][VLANE_NUM-1:0]        store_lane_mask_o,
    output logic [W_PORTS_NUM-1:0]                       done_o,
    output logic [W_PORTS_NUM-1:0]                       protocol_err_o
);
    for (genvar j = 0; j < W_PORTS_NUM; j++) begin : g_port
        ret_state_e                 state;
        logic [VLANE_NUM-1:0]       mask_q, slot_full, vld, rdy, cap;
        logic [VLANE_NUM-1:0][31:0] slot_data;
        logic [BW-1:0]              beats_q, cnt;
        logic                       active, complete, push, pop, last, full, empty;
        ret_beat_t                  din, dout;
        for (genvar i = 0; i < VLANE_NUM; i++) begin : g_lane
            assign vld[i]             = lane_valid_i[i][j];
            assign lane_ready_o[i][j] = rdy[i];
        end
        assign active   = state == RET_COLLECT && beats_q != '0;
        assign rdy      = {VLANE_NUM{active}} & mask_q & ~slot_full;
        assign cap      = vld & rdy;
        assign complete = active && mask_q != '0 && &(slot_full | ~mask_q);
        assign pop      = !empty && store_ready_i[j];
        assign push     = complete && (!full || pop);
        assign last     = push && (cnt + BW'(1)) == beats_q;
        // beat image: unmasked lanes read as zero regardless of stale slot contents
        always_comb begin
            din.mask = mask_q;
            for (int i = 0; i < VLANE_NUM; i++) din.data[i] = mask_q[i] ? slot_data[i] : 32'd0;
        end
        // instruction FSM, beat counter and lane slots
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state     <= RET_IDLE;
                mask_q    <= '0;
                beats_q   <= '0;
                cnt       <= '0;
                slot_full <= '0;
                slot_data <= '0;
            end else begin
                case (state)
                    RET_IDLE: if (start_i[j]) begin
                        state   <= RET_COLLECT;
                        mask_q  <= lane_mask_i[j];
                        beats_q <= beats_i[j];
                        cnt     <= '0;
                    end
                    RET_COLLECT: if (beats_q == '0 || mask_q == '0 || last) state <= RET_DRAIN;
                    default: if (empty) state <= RET_IDLE;
                endcase
                if (push) cnt <= cnt + BW'(1);
                slot_full <= push ? '0 : slot_full | cap;
                for (int i = 0; i < VLANE_NUM; i++) if (cap[i]) slot_data[i] <= lane_data_i[i][j];
            end
        end
        vlane_ret_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .push  (push),
            .pop   (pop),
            .din   (din),
            .dout  (dout),
            .full  (full),
            .empty (empty)
        );
        assign store_valid_o[j]     = !empty;
        assign store_data_o[j]      = empty ? '0 : dout.data;
        assign store_lane_mask_o[j] = empty ? '0 : dout.mask;
        assign done_o[j]            = state == RET_DRAIN && empty;
`ifdef VLANE_RET_PROTO_CHECK_EN
        logic err_q;
        // sticky flag for lane traffic while idle or on lanes outside the latched mask
        always_ff @(posedge clk_i) begin
            if (rst_i) err_q <= 1'b0;
            else if ((state == RET_IDLE && |vld) || |(vld & ~mask_q)) err_q <= 1'b1;
        end
        assign protocol_err_o[j] = err_q;
`else
        assign protocol_err_o[j] = 1'b0;
`endif
    end
endmodule
